// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor: the carry chain is cut into STAGES slices, one per stage.
// Define SATURATE_EN to clamp overflowing results to the signed limit in the last stage.
module pipelined_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int SW  = WIDTH / STAGES;
  localparam int LST = STAGES - 1;
  localparam int MSB = WIDTH - 1;

  logic             valid_q [STAGES];
  logic [WIDTH-1:0] a_q     [STAGES];
  logic [WIDTH-1:0] bb_q    [STAGES];
  logic [WIDTH-1:0] s_q     [STAGES];
  logic             carry_q [STAGES];
  logic             ovf_q;

  logic [WIDTH-1:0] a_d     [STAGES];
  logic [WIDTH-1:0] bb_d    [STAGES];
  logic [WIDTH-1:0] s_d     [STAGES];
  logic             carry_d [STAGES];
  logic             ovf_d;

  logic [WIDTH-1:0] stgA    [STAGES];
  logic [WIDTH-1:0] stgB    [STAGES];
  logic [WIDTH-1:0] stgS    [STAGES];
  logic             stgC    [STAGES];
  logic [SW-1:0]    sliceSum[STAGES];

  logic stall;

  assign stall    = valid_q[LST] & ~out_ready;
  assign in_ready = ~stall;

  always_comb begin
    // Stage 0 sees the transformed operands; later stages see the previous stage's registers.
    stgA[0] = a;
    stgB[0] = sub ? ~b : b;
    stgS[0] = '0;
    stgC[0] = sub ? ~c_in : c_in;
    for (int k = 1; k < STAGES; k++) begin
      stgA[k] = a_q[k-1];
      stgB[k] = bb_q[k-1];
      stgS[k] = s_q[k-1];
      stgC[k] = carry_q[k-1];
    end

    for (int k = 0; k < STAGES; k++) begin
      {carry_d[k], sliceSum[k]} = {1'b0, stgA[k][k*SW +: SW]}
                                + {1'b0, stgB[k][k*SW +: SW]}
                                + {{SW{1'b0}}, stgC[k]};
      a_d[k]               = stgA[k];
      bb_d[k]              = stgB[k];
      s_d[k]               = stgS[k];
      s_d[k][k*SW +: SW]   = sliceSum[k];
    end

    ovf_d = (stgA[LST][MSB] == stgB[LST][MSB]) & (s_d[LST][MSB] != stgA[LST][MSB]);
`ifdef SATURATE_EN
    if (ovf_d) begin
      s_d[LST] = stgA[LST][MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  // Every stage holds while the consumer refuses a valid result; bubbles travel like beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        a_q[k]     <= '0;
        bb_q[k]    <= '0;
        s_q[k]     <= '0;
        carry_q[k] <= 1'b0;
      end
      ovf_q <= 1'b0;
    end else if (!stall) begin
      valid_q[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) begin
        valid_q[k] <= valid_q[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]     <= a_d[k];
        bb_q[k]    <= bb_d[k];
        s_q[k]     <= s_d[k];
        carry_q[k] <= carry_d[k];
      end
      ovf_q <= ovf_d;
    end
  end

  assign out_valid = valid_q[LST];
  assign sum       = s_q[LST];
  assign c_out     = carry_q[LST];
  assign ovf       = ovf_q;

endmodule
